// File: rtl/bmp_stream_encoder.sv
// Streaming 24-bit BMP writer: emits the 54-byte file header, then the pixel rows
// as BGR bytes with zero padding up to a 4-byte stride, one byte per handshake.
module bmp_stream_encoder #(
  parameter int WIDTH       = 768,
  parameter int HEIGHT      = 512,
  parameter int PIX_PER_CLK = 2,
  parameter int TOP_DOWN    = 0
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [24*PIX_PER_CLK-1:0]  in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic                       out_last,
  output logic                       Write_Done
);

  localparam int ROW_BYTES  = 3 * WIDTH;
  localparam int PAD_BYTES  = (4 - (ROW_BYTES % 4)) % 4;
  localparam int STRIDE     = ROW_BYTES + PAD_BYTES;
  localparam int IMG_BYTES  = STRIDE * HEIGHT;
  localparam int FILE_BYTES = 54 + IMG_BYTES;
  localparam bit HAS_PAD    = (PAD_BYTES != 0);

  localparam int BW = $clog2(3 * PIX_PER_CLK);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [BW-1:0] BYTE_LAST = BW'(3 * PIX_PER_CLK - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - PIX_PER_CLK);
  localparam logic [CW-1:0] COL_STEP  = CW'(PIX_PER_CLK);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
  localparam logic [1:0]    PAD_LAST  = 2'(PAD_BYTES - 1);

  localparam logic [31:0] FILE_W = 32'(FILE_BYTES);
  localparam logic [31:0] IMG_W  = 32'(IMG_BYTES);
  localparam logic [31:0] WID_W  = 32'(WIDTH);
  // Top-down images store the height as a negative two's-complement value.
  localparam logic signed [31:0] HGT_W = (TOP_DOWN != 0) ? -32'(HEIGHT) : 32'(HEIGHT);

  typedef enum logic [2:0] {IDLE, HEADER, PIXEL, PAD, DONE} state_t;

  state_t                    state_q, state_d;
  logic [5:0]                hdr_idx_q;
  logic [24*PIX_PER_CLK-1:0] beat_p0;
  logic                      vld_p0;
  logic [BW-1:0]             byte_idx_q;
  logic [CW-1:0]             col_q;
  logic [RW-1:0]             row_q;
  logic [1:0]                pad_q;

  logic xfer, acc, beat_last, col_last, row_last, pad_last;

  function automatic logic [7:0] byte_of(input logic [31:0] v, input logic [1:0] k);
    return v[{k, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [5:0] i);
    logic [7:0] b;
    b = 8'h00;
    if (i == 6'd0)                      b = 8'h42;
    else if (i == 6'd1)                 b = 8'h4D;
    else if (i >= 6'd2  && i <= 6'd5)   b = byte_of(FILE_W, 2'(i - 6'd2));
    else if (i >= 6'd10 && i <= 6'd13)  b = byte_of(32'd54, 2'(i - 6'd10));
    else if (i >= 6'd14 && i <= 6'd17)  b = byte_of(32'd40, 2'(i - 6'd14));
    else if (i >= 6'd18 && i <= 6'd21)  b = byte_of(WID_W, 2'(i - 6'd18));
    else if (i >= 6'd22 && i <= 6'd25)  b = byte_of(HGT_W, 2'(i - 6'd22));
    else if (i == 6'd26)                b = 8'd1;
    else if (i == 6'd28)                b = 8'd24;
    else if (i >= 6'd34 && i <= 6'd37)  b = byte_of(IMG_W, 2'(i - 6'd34));
    return b;
  endfunction

  assign xfer      = out_valid && out_ready;
  assign acc       = in_valid && in_ready;
  assign beat_last = (byte_idx_q == BYTE_LAST);
  assign col_last  = (col_q == COL_LAST);
  assign row_last  = (row_q == ROW_LAST);
  assign pad_last  = (pad_q == PAD_LAST);

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    out_last   = 1'b0;
    Write_Done = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = HEADER;
      HEADER: begin
        out_valid = 1'b1;
        out_data  = hdr_byte(hdr_idx_q);
        if (xfer && hdr_idx_q == 6'd53) state_d = PIXEL;
      end
      PIXEL: begin
        in_ready  = !vld_p0;
        out_valid = vld_p0;
        out_data  = beat_p0[{byte_idx_q, 3'b000} +: 8];
        out_last  = !HAS_PAD && beat_last && col_last && row_last;
        if (xfer && beat_last && col_last) begin
          if (HAS_PAD)       state_d = PAD;
          else if (row_last) state_d = DONE;
        end
      end
      PAD: begin
        out_valid = 1'b1;
        out_last  = pad_last && row_last;
        if (xfer && pad_last) state_d = row_last ? DONE : PIXEL;
      end
      DONE: begin
        Write_Done = 1'b1;
        if (start) state_d = HEADER;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= IDLE;
      hdr_idx_q  <= '0;
      vld_p0     <= 1'b0;
      byte_idx_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      pad_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            hdr_idx_q  <= '0;
            vld_p0     <= 1'b0;
            byte_idx_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            pad_q      <= '0;
          end
        end
        HEADER: if (xfer) hdr_idx_q <= (hdr_idx_q == 6'd53) ? 6'd0 : hdr_idx_q + 6'd1;
        PIXEL: begin
          if (acc) vld_p0 <= 1'b1;
          if (xfer) begin
            if (beat_last) begin
              byte_idx_q <= '0;
              vld_p0     <= 1'b0;
              if (col_last) begin
                col_q <= '0;
                if (!HAS_PAD && !row_last) row_q <= row_q + RW'(1);
              end else begin
                col_q <= col_q + COL_STEP;
              end
            end else begin
              byte_idx_q <= byte_idx_q + BW'(1);
            end
          end
        end
        PAD: begin
          if (xfer) begin
            if (pad_last) begin
              pad_q <= '0;
              if (!row_last) row_q <= row_q + RW'(1);
            end else begin
              pad_q <= pad_q + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Beat data register: only its valid flag needs reset.
  always_ff @(posedge HCLK) begin
    if (acc) beat_p0 <= in_data;
  end

endmodule

// File: tb/tb_bmp_stream_encoder.sv
// Randomised bench for bmp_stream_encoder: three configurations share one driver,
// and every emitted byte is compared with a file image built from the BMP rules.
module tb_bmp_stream_encoder;

  logic        HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        rst_n, start, in_valid, out_ready;
  logic [47:0] in_data;
  logic [1:0]  sel;

  logic [2:0]  rdy_v, ov_v, ol_v, wd_v;
  logic [7:0]  od_v [3];
  logic        m_in_ready, m_valid, m_last, m_wd;
  logic [7:0]  m_data;

  int          n_vec, n_err;
  int          cw, ch, cppc, ctd;
  logic [23:0] pix_q [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  got_q [$];

  bmp_stream_encoder #(.WIDTH(3), .HEIGHT(2), .PIX_PER_CLK(1), .TOP_DOWN(0)) u_a (
    .HCLK(HCLK), .HRESETn(rst_n), .start(start && sel == 2'd0),
    .in_valid(in_valid && sel == 2'd0), .in_ready(rdy_v[0]), .in_data(in_data[23:0]),
    .out_valid(ov_v[0]), .out_ready(out_ready), .out_data(od_v[0]),
    .out_last(ol_v[0]), .Write_Done(wd_v[0]));

  bmp_stream_encoder #(.WIDTH(3), .HEIGHT(2), .PIX_PER_CLK(1), .TOP_DOWN(1)) u_b (
    .HCLK(HCLK), .HRESETn(rst_n), .start(start && sel == 2'd1),
    .in_valid(in_valid && sel == 2'd1), .in_ready(rdy_v[1]), .in_data(in_data[23:0]),
    .out_valid(ov_v[1]), .out_ready(out_ready), .out_data(od_v[1]),
    .out_last(ol_v[1]), .Write_Done(wd_v[1]));

  bmp_stream_encoder #(.WIDTH(4), .HEIGHT(1), .PIX_PER_CLK(2), .TOP_DOWN(0)) u_c (
    .HCLK(HCLK), .HRESETn(rst_n), .start(start && sel == 2'd2),
    .in_valid(in_valid && sel == 2'd2), .in_ready(rdy_v[2]), .in_data(in_data),
    .out_valid(ov_v[2]), .out_ready(out_ready), .out_data(od_v[2]),
    .out_last(ol_v[2]), .Write_Done(wd_v[2]));

  always_comb begin
    m_in_ready = rdy_v[sel];
    m_valid    = ov_v[sel];
    m_last     = ol_v[sel];
    m_wd       = wd_v[sel];
    m_data     = od_v[sel];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put32(input logic [31:0] v);
    for (int i = 0; i < 4; i++) exp_q.push_back(v[8*i +: 8]);
  endtask

  task automatic set_cfg(input logic [1:0] s);
    sel = s;
    case (s)
      2'd0:    begin cw = 3; ch = 2; cppc = 1; ctd = 0; end
      2'd1:    begin cw = 3; ch = 2; cppc = 1; ctd = 1; end
      default: begin cw = 4; ch = 1; cppc = 2; ctd = 0; end
    endcase
  endtask

  // Expected file image: header fields, then rows of B,G,R bytes padded to a 4-byte stride.
  task automatic build_model(input bit directed);
    int stride, img;
    logic [23:0] p;
    exp_q.delete();
    pix_q.delete();
    for (int i = 0; i < cw * ch; i++) pix_q.push_back(24'($urandom));
    if (directed) begin
      pix_q[0] = 24'hAABBCC;
      pix_q[1] = 24'h112233;
    end
    stride = ((3 * cw + 3) / 4) * 4;
    img    = stride * ch;
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h4D);
    put32(32'(54 + img));
    put32(32'd0);
    put32(32'd54);
    put32(32'd40);
    put32(32'(cw));
    put32((ctd != 0) ? 32'(-ch) : 32'(ch));
    put32(32'h0018_0001);
    put32(32'd0);
    put32(32'(img));
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h00);
    for (int r = 0; r < ch; r++) begin
      for (int c = 0; c < cw; c++) begin
        p = pix_q[r * cw + c];
        exp_q.push_back(p[7:0]);
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[23:16]);
      end
      for (int k = 3 * cw; k < stride; k++) exp_q.push_back(8'h00);
    end
  endtask

  function automatic logic [47:0] beat_of(input int k);
    logic [47:0] b;
    b = '0;
    for (int j = 0; j < cppc; j++)
      if (k * cppc + j < pix_q.size()) b[24*j +: 24] = pix_q[k * cppc + j];
    return b;
  endfunction

  task automatic run_frame(input bit rnd, input bit directed, input int poke_at, input int reset_at);
    int bp, cyc, nb, idx;
    bit hold, poked, aborted, acc;
    logic [7:0] hd;
    logic hl;
    bp = 0; cyc = 0; hold = 0; poked = 0; aborted = 0;
    build_model(directed);
    nb = cw * ch / cppc;
    got_q.delete();
    @(posedge HCLK); #1;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge HCLK); #1;
    start = 1'b0;
    out_ready = !rnd || ($urandom % 3 != 0);
    in_data = beat_of(0);
    @(negedge HCLK);
    check("start_vld", 32'(m_valid), 32'd1);
    check("start_byte", 32'(m_data), 32'h42);
    check("start_wd", 32'(m_wd), 32'd0);
    while (got_q.size() < exp_q.size() && cyc < 4000) begin
      if (hold) begin
        check("stall_vld", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'(hd));
        check("stall_last", 32'(m_last), 32'(hl));
      end
      acc = in_valid && m_in_ready;
      if (m_valid && out_ready) begin
        idx = got_q.size();
        check($sformatf("byte%0d", idx), 32'(m_data), 32'(exp_q[idx]));
        check($sformatf("last%0d", idx), 32'(m_last), 32'(idx == exp_q.size() - 1));
        got_q.push_back(m_data);
      end
      hold = m_valid && !out_ready;
      hd = m_data;
      hl = m_last;
      if (reset_at >= 0 && got_q.size() >= reset_at) begin
        aborted = 1;
        break;
      end
      @(posedge HCLK); #1;
      if (acc) bp++;
      start = (poke_at >= 0 && !poked && got_q.size() >= poke_at);
      if (start) poked = 1;
      in_valid  = (bp < nb) && (!rnd || ($urandom % 4 != 0));
      in_data   = beat_of(bp);
      out_ready = !rnd || ($urandom % 3 != 0);
      @(negedge HCLK);
      cyc++;
    end
    if (aborted) begin
      rst_n = 1'b0;
      #1;
      check("rst_vld", 32'(m_valid), 32'd0);
      check("rst_data", 32'(m_data), 32'd0);
      check("rst_last", 32'(m_last), 32'd0);
      check("rst_rdy", 32'(m_in_ready), 32'd0);
      check("rst_wd", 32'(m_wd), 32'd0);
      start = 1'b0; in_valid = 1'b0;
      @(posedge HCLK); #1;
      rst_n = 1'b1;
      repeat (4) @(posedge HCLK);
      @(negedge HCLK);
      check("post_rst_vld", 32'(m_valid), 32'd0);
      check("post_rst_rdy", 32'(m_in_ready), 32'd0);
    end else begin
      check("byte_count", 32'(got_q.size()), 32'(exp_q.size()));
      @(posedge HCLK); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge HCLK);
      check("done_wd", 32'(m_wd), 32'd1);
      check("done_vld", 32'(m_valid), 32'd0);
      check("done_rdy", 32'(m_in_ready), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    set_cfg(2'd0);
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("reset_vld", 32'(m_valid), 32'd0);
    check("reset_data", 32'(m_data), 32'd0);
    check("reset_last", 32'(m_last), 32'd0);
    check("reset_rdy", 32'(m_in_ready), 32'd0);
    check("reset_wd", 32'(m_wd), 32'd0);
    @(posedge HCLK); #1;
    rst_n = 1'b1;
    @(negedge HCLK);
    check("idle_vld", 32'(m_valid), 32'd0);

    run_frame(0, 0, -1, -1);
    check("file_size_b2", 32'(got_q[2]), 32'h4E);
    check("file_size_b3", 32'(got_q[3]), 32'h00);
    check("img_size_b34", 32'(got_q[34]), 32'h18);
    check("pad_row0", 32'({got_q[63], got_q[64], got_q[65]}), 32'd0);
    check("frame_len", 32'(got_q.size()), 32'd78);

    set_cfg(2'd1);
    run_frame(0, 0, -1, -1);
    check("topdown_b22", 32'(got_q[22]), 32'hFE);
    check("topdown_b25", 32'(got_q[25]), 32'hFF);

    set_cfg(2'd2);
    run_frame(0, 1, -1, -1);
    check("ppc2_pix_lo", 32'({got_q[54], got_q[55], got_q[56]}), 32'hCCBBAA);
    check("ppc2_pix_hi", 32'({got_q[57], got_q[58], got_q[59]}), 32'h332211);
    check("ppc2_len", 32'(got_q.size()), 32'd66);

    set_cfg(2'd0);
    repeat (3) run_frame(1, 0, -1, -1);
    run_frame(1, 0, 60, -1);
    run_frame(1, 0, -1, 70);
    run_frame(1, 0, -1, -1);
    set_cfg(2'd2);
    run_frame(1, 0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
